// File: rtl/fifo1r1w_rdstage.sv
// Read-side drain stage for fifo1r1w: pops the FIFO and re-presents words on a registered
// valid/ready port through a main+skid buffer. Optional pop counter: define RDSTAGE_POPCNT_EN.
module fifo1r1w_rdstage #(
  parameter int DWID   = 8,
  parameter int CNTWID = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            fifo_empty,
  input  logic [DWID-1:0] fifo_rdata,
  output logic            fifo_ren,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DWID-1:0] out_data
`ifdef RDSTAGE_POPCNT_EN
  ,
  output logic [CNTWID-1:0] pop_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t          state_r;
  logic [DWID-1:0] main_r;
  logic [DWID-1:0] skid_r;
  logic            valid_r;
  logic            acc_s;

  // The pop decision never looks at out_ready, so the consumer's timing stays out of the FIFO.
  assign fifo_ren  = !rst && !flush && !fifo_empty && (state_r != ST_TWO);
  assign acc_s     = valid_r && out_ready;
  assign out_valid = valid_r;
  assign out_data  = main_r;

  // Occupancy FSM with main/skid buffer; out_valid is registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_EMPTY;
      main_r  <= {DWID{1'b0}};
      skid_r  <= {DWID{1'b0}};
      valid_r <= 1'b0;
    end else if (flush) begin
      state_r <= ST_EMPTY;
      main_r  <= {DWID{1'b0}};
      skid_r  <= {DWID{1'b0}};
      valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (fifo_ren) begin
            state_r <= ST_ONE;
            main_r  <= fifo_rdata;
            valid_r <= 1'b1;
          end else begin
            state_r <= ST_EMPTY;
            valid_r <= 1'b0;
          end
        end
        ST_ONE: begin
          if (fifo_ren && acc_s) begin
            state_r <= ST_ONE;
            main_r  <= fifo_rdata;
            valid_r <= 1'b1;
          end else if (fifo_ren) begin
            state_r <= ST_TWO;
            skid_r  <= fifo_rdata;
            valid_r <= 1'b1;
          end else if (acc_s) begin
            state_r <= ST_EMPTY;
            valid_r <= 1'b0;
          end else begin
            state_r <= ST_ONE;
            valid_r <= 1'b1;
          end
        end
        ST_TWO: begin
          // The skid word is always younger than main, so it moves up on a transfer.
          if (acc_s) begin
            state_r <= ST_ONE;
            main_r  <= skid_r;
            valid_r <= 1'b1;
          end else begin
            state_r <= ST_TWO;
            valid_r <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_EMPTY;
          main_r  <= {DWID{1'b0}};
          skid_r  <= {DWID{1'b0}};
          valid_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef RDSTAGE_POPCNT_EN
  logic [CNTWID-1:0] pop_cnt_r;

  // Count every pop, wrapping naturally; cleared together with the buffered words.
  always_ff @(posedge clk) begin
    if (rst) begin
      pop_cnt_r <= {CNTWID{1'b0}};
    end else if (flush) begin
      pop_cnt_r <= {CNTWID{1'b0}};
    end else if (fifo_ren) begin
      pop_cnt_r <= pop_cnt_r + {{(CNTWID-1){1'b0}}, 1'b1};
    end else begin
      pop_cnt_r <= pop_cnt_r;
    end
  end

  assign pop_cnt = pop_cnt_r;
`else
  // CNTWID stays on the parameter list so both builds instantiate identically.
  if (CNTWID < 1) begin : g_cntwid_unused
  end
`endif

endmodule

// File: tb/tb_fifo1r1w_rdstage.sv
// Self-checking bench for fifo1r1w_rdstage: queue-based model of the bench FIFO and the
// stage's buffered words, checked every cycle, plus hand-computed directed expectations.
module tb_fifo1r1w_rdstage;
  localparam int DWID   = 8;
  localparam int CNTWID = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  logic            fifo_empty = 1'b1;
  logic [DWID-1:0] fifo_rdata = '0;
  logic            out_ready = 1'b0;
  wire             fifo_ren;
  wire             out_valid;
  wire [DWID-1:0]  out_data;
`ifdef RDSTAGE_POPCNT_EN
  wire [CNTWID-1:0] pop_cnt;
`endif

  int compared = 0;
  int mismatched = 0;
  logic [DWID-1:0] fq[$];
  logic [DWID-1:0] mq[$];
  logic [DWID-1:0] dlog[$];
  int dcyc[$];
  int cyc = 0;
  int first_pop = -1;
  int mcnt = 0;
  logic prev_valid = 1'b0;
  logic prev_excuse = 1'b1;

  fifo1r1w_rdstage #(.DWID(DWID), .CNTWID(CNTWID)) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .fifo_empty(fifo_empty),
    .fifo_rdata(fifo_rdata),
    .fifo_ren(fifo_ren),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data)
`ifdef RDSTAGE_POPCNT_EN
    , .pop_cnt(pop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs at negedge, compare against the model, advance the model.
  task automatic step(input logic r, input logic f, input logic rdy);
    logic exp_ren;
    logic exp_valid;
    logic acc;
    rst = r;
    flush = f;
    out_ready = rdy;
    fifo_empty = (fq.size() == 0);
    fifo_rdata = (fq.size() > 0) ? fq[0] : '0;
    #1;
    exp_valid = (mq.size() > 0);
    exp_ren = !r && !f && (fq.size() > 0) && (mq.size() < 2);
    check("fifo_ren", fifo_ren, exp_ren);
    check("out_valid", out_valid, exp_valid);
    if (exp_valid) check("out_data", out_data, mq[0]);
    if (prev_valid && !prev_excuse) check("valid_hold", out_valid, 1'b1);
`ifdef RDSTAGE_POPCNT_EN
    check("pop_cnt", pop_cnt, 32'(mcnt % (1 << CNTWID)));
`endif
    acc = exp_valid && rdy;
    if (acc) begin
      dlog.push_back(mq[0]);
      dcyc.push_back(cyc);
    end
    prev_valid = out_valid;
    prev_excuse = acc || r || f;
    if (r || f) begin
      mq.delete();
      mcnt = 0;
    end else begin
      if (acc) void'(mq.pop_front());
      if (exp_ren) begin
        mq.push_back(fq.pop_front());
        mcnt++;
        if (first_pop < 0) first_pop = cyc;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic clear_log();
    dlog.delete();
    dcyc.delete();
    first_pop = -1;
  endtask

  initial begin
    @(posedge clk);
    @(negedge clk);

    // Reset with a non-empty FIFO, then streaming 0x11..0x18
    for (int i = 0; i < 8; i++) fq.push_back(8'(8'h11 + i));
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 1'b1);
      check("rst_ren", fifo_ren, 32'h0);
      check("rst_valid", out_valid, 32'h0);
      check("rst_data", out_data, 32'h0);
    end
    clear_log();
    step(1'b0, 1'b0, 1'b1);
    check("ren_after_rst", fifo_ren, 32'h1);
    repeat (10) step(1'b0, 1'b0, 1'b1);
    check("stream_count", dlog.size(), 32'd8);
    for (int i = 0; i < 8 && i < dlog.size(); i++) begin
      check("stream_word", dlog[i], 32'(8'h11 + i));
      check("stream_cycle", dcyc[i], 32'(first_pop + 1 + i));
    end

    // Stall fills main and skid, then drains in order
    clear_log();
    fq = '{8'h11, 8'h12, 8'h13};
    repeat (4) step(1'b0, 1'b0, 1'b0);
    check("stall_ren", fifo_ren, 32'h0);
    check("stall_valid", out_valid, 32'h1);
    check("stall_data", out_data, 32'h11);
    repeat (6) step(1'b0, 1'b0, 1'b1);
    check("skid_count", dlog.size(), 32'd3);
    for (int i = 0; i < 3 && i < dlog.size(); i++) check("skid_word", dlog[i], 32'(8'h11 + i));

    // Single word then underflow
    clear_log();
    fq = '{8'hA5};
    repeat (4) step(1'b0, 1'b0, 1'b1);
    check("under_count", dlog.size(), 32'd1);
    if (dlog.size() > 0) check("under_word", dlog[0], 32'hA5);
    check("under_valid", out_valid, 32'h0);
    check("under_ren", fifo_ren, 32'h0);

    // Flush while holding two words
    clear_log();
    fq = '{8'h21, 8'h22, 8'h23};
    repeat (2) step(1'b0, 1'b0, 1'b0);
    check("pre_flush_data", out_data, 32'h21);
    step(1'b0, 1'b1, 1'b0);
    check("flush_valid", out_valid, 32'h0);
    repeat (4) step(1'b0, 1'b0, 1'b1);
    check("flush_count", dlog.size(), 32'd1);
    if (dlog.size() > 0) check("flush_word", dlog[0], 32'h23);

    // Reset in the middle of a stall
    fq = '{8'h41, 8'h42, 8'h43};
    repeat (2) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("midrst_valid", out_valid, 32'h0);
    check("midrst_data", out_data, 32'h0);
    clear_log();
    repeat (3) step(1'b0, 1'b0, 1'b1);
    check("midrst_first", (dlog.size() > 0) ? dlog[0] : 8'h00, 32'h43);

`ifdef RDSTAGE_POPCNT_EN
    // Pop counter wraps at 2^CNTWID and clears on flush
    step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 18; i++) fq.push_back(8'(8'h30 + i));
    repeat (22) step(1'b0, 1'b0, 1'b1);
    check("popcnt_wrap", pop_cnt, 32'h2);
    step(1'b0, 1'b1, 1'b1);
    check("popcnt_flush", pop_cnt, 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
